// File: rtl/ddfs_sweep_ctrl.sv
// ddfs_sweep_ctrl: frequency sweep sequencer that drives the ddfs fcontrol word.
// It steps fcontrol from F_START towards F_STOP and holds each value for a
// programmable dwell. Supported modes are one-shot, looping and CW (F_STEP = 0).
// Optional build macro DDFS_SWEEP_BIDIR_EN turns the sweep into a triangle
// (up to F_STOP, then back down to F_START).
module ddfs_sweep_ctrl #(
  parameter int FW      = 23,
  parameter int DWELL_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [FW-1:0] cfg_wdata,
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] fcontrol,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, RUN_DN} state_t;

  state_t               state;
  logic [FW-1:0]        f_start;
  logic [FW-1:0]        f_stop;
  logic [FW-1:0]        f_step;
  logic                 loop_en;
  logic [DWELL_W-1:0]   dwell;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [DWELL_W-1:0]   dwell_ld;
  logic [FW:0]          up_nxt;
  logic                 up_ok;

  // Unsigned add with the carry kept; the extra bit flags a wrap past full scale.
  function automatic logic [FW:0] add_wide(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Unsigned subtract with the borrow kept in the top bit.
  function automatic logic [FW:0] sub_wide(input logic [FW-1:0] a, input logic [FW-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // A dwell of 0 behaves as 1. The counter counts down to zero, so load D-1.
  assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign up_nxt   = add_wide(fcontrol, f_step);
  assign up_ok    = !up_nxt[FW] && (up_nxt[FW-1:0] <= f_stop);

`ifdef DDFS_SWEEP_BIDIR_EN
  logic [FW:0] dn_nxt;
  logic        dn_ok;
  logic [FW:0] rs_nxt;
  logic        rs_ok;
  assign dn_nxt = sub_wide(fcontrol, f_step);
  assign dn_ok  = !dn_nxt[FW] && (dn_nxt[FW-1:0] >= f_start);
  // A looping triangle restarts one step above F_START, so F_START is not output twice.
  assign rs_nxt = add_wide(f_start, f_step);
  assign rs_ok  = !rs_nxt[FW] && (rs_nxt[FW-1:0] <= f_stop);
`endif

  // Sweep state machine, config registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      f_start   <= '0;
      f_stop    <= '0;
      f_step    <= '0;
      loop_en   <= 1'b0;
      dwell     <= '0;
      dwell_cnt <= '0;
      fcontrol  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        fcontrol <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              // A config write in the same cycle as start is dropped.
              state     <= RUN;
              busy      <= 1'b1;
              fcontrol  <= f_start;
              dwell_cnt <= dwell_ld;
            end else if (cfg_we) begin
              case (cfg_addr)
                2'd0: f_start <= cfg_wdata;
                2'd1: f_stop  <= cfg_wdata;
                2'd2: f_step  <= cfg_wdata;
                default: begin
                  loop_en <= cfg_wdata[FW-1];
                  dwell   <= cfg_wdata[DWELL_W-1:0];
                end
              endcase
            end
          end
          RUN: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else if (f_step == '0) begin
              // CW tone: hold F_START until abort or reset.
              dwell_cnt <= dwell_ld;
            end else if (up_ok) begin
              fcontrol  <= up_nxt[FW-1:0];
              dwell_cnt <= dwell_ld;
`ifdef DDFS_SWEEP_BIDIR_EN
            end else if (dn_ok) begin
              state     <= RUN_DN;
              fcontrol  <= dn_nxt[FW-1:0];
              dwell_cnt <= dwell_ld;
`endif
            end else if (loop_en) begin
              fcontrol  <= f_start;
              dwell_cnt <= dwell_ld;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              fcontrol <= '0;
              done     <= 1'b1;
            end
          end
`ifdef DDFS_SWEEP_BIDIR_EN
          RUN_DN: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end else if (dn_ok) begin
              fcontrol  <= dn_nxt[FW-1:0];
              dwell_cnt <= dwell_ld;
            end else if (loop_en) begin
              state     <= RUN;
              fcontrol  <= rs_ok ? rs_nxt[FW-1:0] : f_start;
              dwell_cnt <= dwell_ld;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              fcontrol <= '0;
              done     <= 1'b1;
            end
          end
`endif
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            fcontrol <= '0;
          end
        endcase
      end
    end
  end

endmodule
